// File: rtl/text_writer_if.sv
// Command, buffer-port and cursor bundle between text_writer (slave) and its
// keyboard/buffer environment (master).
interface text_writer_if;
  logic       en;
  logic [7:0] w_ascii;
  logic       is_dir;
  logic       busy;
  logic       drop;
  logic       wr_en;
  logic [4:0] wr_row;
  logic [6:0] wr_col;
  logic [7:0] wr_data;
  logic [4:0] rd_row;
  logic [6:0] rd_col;
  logic [7:0] rd_data;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  // en is a one-cycle strobe taken only while busy=0; a strobe seen while busy=1
  // is discarded and answered with a one-cycle drop pulse. rd_data follows rd_* by one cycle.
  modport slave (
    input  en, w_ascii, is_dir, rd_data,
    output busy, drop, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col, cur_x, cur_y
  );
  modport master (
    output en, w_ascii, is_dir, rd_data,
    input  busy, drop, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col, cur_x, cur_y
  );
endinterface

// File: rtl/text_writer.sv
// Write side of the 70x30 text buffer: clears, types, edits, scrolls, tracks the cursor.
// Optional prompt glyph at column 0 of new lines is enabled by defining TEXT_WRITER_PROMPT_EN.
module text_writer #(
  parameter int         COLS        = 70,
  parameter int         ROWS        = 30,
  parameter logic [7:0] PROMPT_CHAR = 8'h3E
) (
  input  logic          clk,
  input  logic          rst,
  text_writer_if.slave  bus,
  output logic [2:0]    o_dbg_state
);
`ifdef TEXT_WRITER_PROMPT_EN
  localparam logic       PROMPT_EN = 1'b1;
  localparam logic [6:0] PSTART    = 7'd2;
`else
  localparam logic       PROMPT_EN = 1'b0;
  localparam logic [6:0] PSTART    = 7'd0;
`endif
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_SCR_COPY, S_SCR_FILL, S_PROMPT} state_t;

  state_t     r_state, w_state;
  logic [4:0] r_row, w_row;
  logic [6:0] r_col, w_col;
  logic       r_issue_done, w_issue_done;
  logic       r_prompt_pend, w_prompt_pend;
  logic       r_rd_v, w_rd_v, r_rd_v_d, w_rd_v_d;
  logic [4:0] r_rd_row_d, w_rd_row_d;
  logic [6:0] r_rd_col_d, w_rd_col_d;
  logic [6:0] r_cur_x, w_cur_x;
  logic [4:0] r_cur_y, w_cur_y;
  logic       r_wr_en, w_wr_en;
  logic [4:0] r_wr_row, w_wr_row;
  logic [6:0] r_wr_col, w_wr_col;
  logic [7:0] r_wr_data, w_wr_data;
  logic [4:0] r_rd_row, w_rd_row;
  logic [6:0] r_rd_col, w_rd_col;
  logic       r_busy, w_busy;
  logic       r_drop, w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;  r_row <= '0;  r_col <= '0;
      r_issue_done <= 1'b0;  r_prompt_pend <= 1'b0;
      r_rd_v <= 1'b0;  r_rd_v_d <= 1'b0;  r_rd_row_d <= '0;  r_rd_col_d <= '0;
      r_cur_x <= '0;  r_cur_y <= '0;
      r_wr_en <= 1'b0;  r_wr_row <= '0;  r_wr_col <= '0;  r_wr_data <= '0;
      r_rd_row <= '0;  r_rd_col <= '0;
      r_busy <= 1'b1;  r_drop <= 1'b0;
    end else begin
      r_state <= w_state;  r_row <= w_row;  r_col <= w_col;
      r_issue_done <= w_issue_done;  r_prompt_pend <= w_prompt_pend;
      r_rd_v <= w_rd_v;  r_rd_v_d <= w_rd_v_d;  r_rd_row_d <= w_rd_row_d;  r_rd_col_d <= w_rd_col_d;
      r_cur_x <= w_cur_x;  r_cur_y <= w_cur_y;
      r_wr_en <= w_wr_en;  r_wr_row <= w_wr_row;  r_wr_col <= w_wr_col;  r_wr_data <= w_wr_data;
      r_rd_row <= w_rd_row;  r_rd_col <= w_rd_col;
      r_busy <= w_busy;  r_drop <= w_drop;
    end
  end

  always_comb begin
    w_state = r_state;  w_row = r_row;  w_col = r_col;
    w_issue_done = r_issue_done;  w_prompt_pend = r_prompt_pend;
    w_cur_x = r_cur_x;  w_cur_y = r_cur_y;
    w_wr_en = 1'b0;  w_wr_row = r_wr_row;  w_wr_col = r_wr_col;  w_wr_data = r_wr_data;
    w_rd_row = r_rd_row;  w_rd_col = r_rd_col;
    w_rd_v = 1'b0;  w_rd_v_d = r_rd_v;  w_rd_row_d = r_rd_row;  w_rd_col_d = r_rd_col;
    w_drop = bus.en && (r_state != S_IDLE);

    // Scroll copy pipeline: the read presented two edges ago has its data on rd_data now.
    if (r_rd_v_d) begin
      w_wr_en = 1'b1;  w_wr_row = r_rd_row_d - 5'd1;  w_wr_col = r_rd_col_d;  w_wr_data = bus.rd_data;
    end

    case (r_state)
      S_CLEAR: begin
        w_wr_en = 1'b1;  w_wr_row = r_row;  w_wr_col = r_col;  w_wr_data = 8'h00;
        if (r_col != LAST_COL) begin
          w_col = r_col + 7'd1;
        end else if (r_row != LAST_ROW) begin
          w_col = '0;  w_row = r_row + 5'd1;
        end else begin
          w_col = '0;  w_row = '0;
          w_cur_x = PSTART;  w_cur_y = '0;
          w_state = PROMPT_EN ? S_PROMPT : S_IDLE;
        end
      end
      S_IDLE: if (bus.en) begin
        if (bus.is_dir) begin
          case (bus.w_ascii)
            8'h32: if (r_cur_y != LAST_ROW) w_cur_y = r_cur_y + 5'd1;
            8'h34: if (r_cur_x != 7'd0)     w_cur_x = r_cur_x - 7'd1;
            8'h36: if (r_cur_x != LAST_COL) w_cur_x = r_cur_x + 7'd1;
            8'h38: if (r_cur_y != 5'd0)     w_cur_y = r_cur_y - 5'd1;
            default: ;
          endcase
        end else if (bus.w_ascii == 8'h0D) begin
          w_cur_x = PSTART;
          if (r_cur_y == LAST_ROW) begin
            w_state = S_SCR_COPY;  w_row = 5'd1;  w_col = '0;
            w_issue_done = 1'b0;  w_prompt_pend = 1'b1;
          end else begin
            w_cur_y = r_cur_y + 5'd1;
            if (PROMPT_EN) begin
              w_wr_en = 1'b1;  w_wr_row = r_cur_y + 5'd1;  w_wr_col = '0;  w_wr_data = PROMPT_CHAR;
            end
          end
        end else if (bus.w_ascii == 8'h08) begin
          if (r_cur_x != 7'd0) begin
            w_wr_en = 1'b1;  w_wr_row = r_cur_y;  w_wr_col = r_cur_x - 7'd1;  w_wr_data = 8'h00;
            w_cur_x = r_cur_x - 7'd1;
          end else if (r_cur_y != 5'd0) begin
            w_wr_en = 1'b1;  w_wr_row = r_cur_y - 5'd1;  w_wr_col = LAST_COL;  w_wr_data = 8'h00;
            w_cur_x = LAST_COL;  w_cur_y = r_cur_y - 5'd1;
          end
        end else begin
          w_wr_en = 1'b1;  w_wr_row = r_cur_y;  w_wr_col = r_cur_x;  w_wr_data = bus.w_ascii;
          if (r_cur_x != LAST_COL) begin
            w_cur_x = r_cur_x + 7'd1;
          end else begin
            w_cur_x = '0;
            if (r_cur_y != LAST_ROW) begin
              w_cur_y = r_cur_y + 5'd1;
            end else begin
              w_state = S_SCR_COPY;  w_row = 5'd1;  w_col = '0;
              w_issue_done = 1'b0;  w_prompt_pend = 1'b0;
            end
          end
        end
      end
      S_SCR_COPY: begin
        if (!r_issue_done) begin
          w_rd_row = r_row;  w_rd_col = r_col;  w_rd_v = 1'b1;
          if (r_col != LAST_COL) begin
            w_col = r_col + 7'd1;
          end else begin
            w_col = '0;
            if (r_row != LAST_ROW) w_row = r_row + 5'd1;
            else                   w_issue_done = 1'b1;
          end
        end else if (!r_rd_v && !r_rd_v_d) begin
          w_state = S_SCR_FILL;  w_col = '0;
        end
      end
      S_SCR_FILL: begin
        w_wr_en = 1'b1;  w_wr_row = LAST_ROW;  w_wr_col = r_col;  w_wr_data = 8'h00;
        if (r_col != LAST_COL) begin
          w_col = r_col + 7'd1;
        end else begin
          w_col = '0;
          w_state = (PROMPT_EN && r_prompt_pend) ? S_PROMPT : S_IDLE;
        end
      end
      S_PROMPT: begin
        w_wr_en = 1'b1;  w_wr_row = r_cur_y;  w_wr_col = '0;  w_wr_data = PROMPT_CHAR;
        w_prompt_pend = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_CLEAR;
    endcase

    w_busy = (w_state != S_IDLE);
  end

  assign bus.busy    = r_busy;
  assign bus.drop    = r_drop;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_row  = r_wr_row;
  assign bus.wr_col  = r_wr_col;
  assign bus.wr_data = r_wr_data;
  assign bus.rd_row  = r_rd_row;
  assign bus.rd_col  = r_rd_col;
  assign bus.cur_x   = r_cur_x;
  assign bus.cur_y   = r_cur_y;
  assign o_dbg_state = r_state;
endmodule
